next_pc_unit: RTL

Registered program-counter and control-transfer unit for the RV32I multicycle/pipelined core. It owns the fetch PC register and computes JAL, branch and JALR targets for the instruction in execute. It evaluates the branch condition and redirects fetch on taken transfers, emitting a one-cycle flush pulse. Misaligned targets are trapped and the unit is frozen until the trap is acknowledged.

---
 rtl/next_pc_pkg.sv | 26 ++
 rtl/next_pc_unit_if.sv | 35 +++
 rtl/next_pc_unit_branch_cond_gen.sv | 39 +++
 rtl/next_pc_unit.sv | 107 ++++++++++
 4 files changed

// File: rtl/next_pc_pkg.sv
// Shared types and constants for the next-PC / control-transfer unit.
//   xfer_op_t   : control-transfer opcode presented by decode with the execute instruction
//   npc_state_t : next-PC sequencer state
//   INSN_BYTES  : fetch stride and link offset
package next_pc_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_JAL  = 4'd1,
        OP_JALR = 4'd2,
        OP_BEQ  = 4'd3,
        OP_BNE  = 4'd4,
        OP_BLT  = 4'd5,
        OP_BGE  = 4'd6,
        OP_BLTU = 4'd7,
        OP_BGEU = 4'd8
    } xfer_op_t;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } npc_state_t;

    localparam int INSN_BYTES = 4;

endpackage

// File: rtl/next_pc_unit_if.sv
// Bus between the core pipeline and the next-PC unit.
//   master : pipeline side, drives execute-stage operands, stall and trap_ack;
//            receives pc, flush, link, trap, trap_addr
//   slave  : next_pc_unit side, the mirror image
interface next_pc_unit_if #(
    parameter int XLEN = 32
);
    import next_pc_pkg::*;

    logic            stall;
    logic            ex_valid;
    xfer_op_t        ex_op;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic            trap_ack;

    logic [XLEN-1:0] pc;
    logic            flush;
    logic [XLEN-1:0] link;
    logic            trap;
    logic [XLEN-1:0] trap_addr;

    modport master (
        output stall, ex_valid, ex_op, ex_pc, rs1, rs2, imm, trap_ack,
        input  pc, flush, link, trap, trap_addr
    );

    modport slave (
        input  stall, ex_valid, ex_op, ex_pc, rs1, rs2, imm, trap_ack,
        output pc, flush, link, trap, trap_addr
    );

endinterface

// File: rtl/next_pc_unit_branch_cond_gen.sv
// Branch condition evaluator: decides whether the transfer in execute is taken.
// Purely combinational so it can also serve the forwarding-check logic.
//   rs1, rs2 : register operands
//   ex_op    : transfer opcode
//   taken    : 1 when the transfer redirects (JAL/JALR always, NONE never)
module branch_cond_gen
    import next_pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  xfer_op_t        ex_op,
    output logic            taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    always_comb begin
        eq   = (rs1 == rs2);
        lt_s = ($signed(rs1) < $signed(rs2));
        lt_u = (rs1 < rs2);

        taken = 1'b0;
        unique case (ex_op)
            OP_JAL, OP_JALR: taken = 1'b1;
            OP_BEQ:          taken = eq;
            OP_BNE:          taken = !eq;
            OP_BLT:          taken = lt_s;
            OP_BGE:          taken = !lt_s;
            OP_BLTU:         taken = lt_u;
            OP_BGEU:         taken = !lt_u;
            default:         taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC register and control-transfer unit. Computes JAL/branch/JALR targets for
// the execute instruction, redirects fetch on taken transfers with a one-cycle flush,
// and freezes on a misaligned target until the trap is acknowledged.
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset, highest priority
//   bus  : next_pc_unit_if.slave (execute operands, stall, trap_ack in;
//          pc, flush, link, trap, trap_addr out)
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | pc steps by INSN_BYTES, taken transfers redirect and pulse flush
// TRAP  | misaligned target captured, pc frozen, waiting for trap_ack
module next_pc_unit
    import next_pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              IALIGN    = 4
) (
    input  logic           clk,
    input  logic           rst,
    next_pc_unit_if.slave  bus
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSN_BYTES);

    npc_state_t      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic [XLEN-1:0] trap_addr_q, trap_addr_d;

    logic            taken;
    logic [XLEN-1:0] target_rel;
    logic [XLEN-1:0] target_jalr;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            xfer;

    branch_cond_gen #(.XLEN(XLEN)) u_cond (
        .rs1   (bus.rs1),
        .rs2   (bus.rs2),
        .ex_op (bus.ex_op),
        .taken (taken)
    );

    always_comb begin
        target_rel  = bus.ex_pc + bus.imm;
        // JALR clears bit 0 of the sum before the alignment check.
        target_jalr = (bus.rs1 + bus.imm) & ~XLEN'(1);
        target      = (bus.ex_op == OP_JALR) ? target_jalr : target_rel;
        misaligned  = |(target & ALIGN_MASK);
        xfer        = bus.ex_valid && taken && !bus.stall && (state_q == RUN);
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_d     = 1'b0;
        trap_addr_d = trap_addr_q;

        if (!bus.stall) begin
            unique case (state_q)
                RUN: begin
                    if (xfer) begin
                        flush_d = 1'b1;
                        if (misaligned) begin
                            trap_addr_d = target;
                            state_d     = TRAP;
                        end else begin
                            pc_d = target;
                        end
                    end else begin
                        pc_d = pc_q + STEP;
                    end
                end
                TRAP: begin
                    if (bus.trap_ack) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_VEC;
            flush_q     <= 1'b0;
            trap_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_q     <= flush_d;
            trap_addr_q <= trap_addr_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.flush     = flush_q;
    assign bus.trap      = (state_q == TRAP);
    assign bus.trap_addr = trap_addr_q;
    assign bus.link      = bus.ex_pc + STEP;

endmodule
